// File: rtl/mul_norm_if.sv
// Stream bus for the multiplier normalization stage: LZC-side input beat and
// rounding-side output beat, each with its own valid/ready pair.
interface mul_norm_if #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 10
);
    localparam int CNT_WIDTH = $clog2(MANT_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [MANT_WIDTH-1:0] in_mant;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic [CNT_WIDTH-1:0]  in_lzc;

    logic                  out_valid;
    logic                  out_ready;
    logic [MANT_WIDTH-1:0] out_mant;
    logic [EXP_WIDTH-1:0]  out_exp;
    logic                  out_zero;
    logic                  out_uflow;

    modport slave (
        input  in_valid, in_mant, in_exp, in_lzc, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
    );

    modport master (
        output in_valid, in_mant, in_exp, in_lzc, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
    );
endinterface

// File: rtl/mul_norm.sv
// Two-stage normalization shifter: stage 1 picks the shift and applies the
// byte-granular part, stage 2 applies the residual 0..7 bit shift.
module mul_norm #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 10
) (
    input  logic      clk,
    input  logic      rst,
    mul_norm_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(MANT_WIDTH);
    localparam logic [CNT_WIDTH-1:0]     SH_MAX = CNT_WIDTH'(MANT_WIDTH - 1);
    localparam logic signed [EXP_WIDTH:0] ONE_X = (EXP_WIDTH + 1)'(1);

    // stage 1 registers
    logic                  s1_valid_q, s1_valid_d;
    logic [MANT_WIDTH-1:0] s1_mant_q, s1_mant_d;
    logic [2:0]            s1_fsh_q, s1_fsh_d;
    logic [EXP_WIDTH-1:0]  s1_exp_q, s1_exp_d;
    logic                  s1_zero_q, s1_zero_d;
    logic                  s1_uflow_q, s1_uflow_d;

    // output registers
    logic                  out_valid_q, out_valid_d;
    logic [MANT_WIDTH-1:0] out_mant_q, out_mant_d;
    logic [EXP_WIDTH-1:0]  out_exp_q, out_exp_d;
    logic                  out_zero_q, out_zero_d;
    logic                  out_uflow_q, out_uflow_d;

    logic                   out_adv, accept;
    logic [CNT_WIDTH-1:0]   sh_clamp, sh;
    logic signed [EXP_WIDTH:0] exp_ext, diff;
    logic [EXP_WIDTH-1:0]   exp1;
    logic                   zero1, uflow1;

    assign out_adv      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || out_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // Shift selection; the extra exponent bit keeps in_exp - sh from wrapping.
    always_comb begin
        sh_clamp = (bus.in_lzc > SH_MAX) ? SH_MAX : bus.in_lzc;
        exp_ext  = {bus.in_exp[EXP_WIDTH-1], bus.in_exp};
        diff     = exp_ext - $signed({{(EXP_WIDTH + 1 - CNT_WIDTH){1'b0}}, sh_clamp});
        zero1    = (bus.in_mant == '0);
        sh       = sh_clamp;
        exp1     = diff[EXP_WIDTH-1:0];
        uflow1   = 1'b0;
        if (diff < ONE_X) begin
            sh     = (exp_ext > ONE_X) ? CNT_WIDTH'(exp_ext - ONE_X) : '0;
            exp1   = '0;
            uflow1 = 1'b1;
        end
        if (zero1) begin
            exp1   = '0;
            uflow1 = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d = accept || (s1_valid_q && !out_adv);
        s1_mant_d  = s1_mant_q;
        s1_fsh_d   = s1_fsh_q;
        s1_exp_d   = s1_exp_q;
        s1_zero_d  = s1_zero_q;
        s1_uflow_d = s1_uflow_q;
        if (accept) begin
            s1_mant_d  = bus.in_mant << {sh[CNT_WIDTH-1:3], 3'b000};
            s1_fsh_d   = sh[2:0];
            s1_exp_d   = exp1;
            s1_zero_d  = zero1;
            s1_uflow_d = uflow1;
        end
    end

    // Output holds while stalled; otherwise it takes stage 1 (or drains).
    always_comb begin
        out_valid_d = out_valid_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_zero_d  = out_zero_q;
        out_uflow_d = out_uflow_q;
        if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_mant_d  = s1_mant_q << s1_fsh_q;
                out_exp_d   = s1_exp_q;
                out_zero_d  = s1_zero_q;
                out_uflow_d = s1_uflow_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mant_q   <= '0;
            s1_fsh_q    <= '0;
            s1_exp_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_uflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mant_q   <= s1_mant_d;
            s1_fsh_q    <= s1_fsh_d;
            s1_exp_q    <= s1_exp_d;
            s1_zero_q   <= s1_zero_d;
            s1_uflow_q  <= s1_uflow_d;
            out_valid_q <= out_valid_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_zero_q  <= out_zero_d;
            out_uflow_q <= out_uflow_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_uflow = out_uflow_q;
endmodule

// File: tb/tb_mul_norm.sv
// Bench for mul_norm: directed vectors, backpressure and reset scenarios, then
// random traffic checked against an arithmetic model through an in-order queue.
module tb_mul_norm;
    localparam int MW = 24;
    localparam int EW = 10;
    localparam int CW = $clog2(MW);

    typedef struct packed {
        logic [MW-1:0] m;
        logic [EW-1:0] e;
        logic          z;
        logic          u;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_norm_if #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) bus ();
    mul_norm #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result straight from the normalization rules, using plain integers.
    function automatic beat_t model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                    input logic [CW-1:0] l);
        beat_t r;
        int ex, sh;
        r  = '0;
        ex = int'($signed(e));
        sh = (int'(l) > MW - 1) ? MW - 1 : int'(l);
        if (m == '0) begin
            r.z = 1'b1;
            return r;
        end
        if (ex - sh < 1) begin
            sh  = (ex > 1) ? ex - 1 : 0;
            r.u = 1'b1;
        end else begin
            r.e = EW'(ex - sh);
        end
        r.m = m << sh;
        return r;
    endfunction

    beat_t q[$];
    beat_t held;
    logic  stall_q = 1'b0;

    always @(negedge clk) begin
        beat_t act;
        if (rst) begin
            q.delete();
            stall_q = 1'b0;
        end else begin
            act = {bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow};
            chk("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
            if (stall_q) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", act, held);
            end
            if (bus.out_valid) begin
                if (!act.z && !act.u) chk("msb_set", act.m[MW-1], 1);
                if (bus.out_ready) begin
                    chk("beat_avail", q.size() != 0, 1);
                    if (q.size() != 0) chk("beat", act, q.pop_front());
                end
            end
            stall_q = bus.out_valid && !bus.out_ready;
            held    = act;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_mant, bus.in_exp, bus.in_lzc));
        end
    end

    task automatic drive(input logic v, input logic [MW-1:0] m, input logic [EW-1:0] e,
                         input logic [CW-1:0] l);
        bus.in_valid = v;
        bus.in_mant  = m;
        bus.in_exp   = e;
        bus.in_lzc   = l;
    endtask

    task automatic one(input string name, input logic [MW-1:0] m, input logic [EW-1:0] e,
                       input logic [CW-1:0] l, input logic [MW-1:0] xm,
                       input logic [EW-1:0] xe, input logic xz, input logic xu);
        @(posedge clk); #1;
        drive(1'b1, m, e, l);
        @(negedge clk);
        chk({name, "_rdy"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_early"}, bus.out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_mant"}, bus.out_mant, xm);
        chk({name, "_exp"}, bus.out_exp, xe);
        chk({name, "_zero"}, bus.out_zero, xz);
        chk({name, "_uflow"}, bus.out_uflow, xu);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int lz;
        logic [MW-1:0] m;
        logic [EW-1:0] e;
        logic [CW-1:0] l;

        drive(1'b0, '0, '0, '0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_out", {bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow}, 0);
        rst = 1'b0;

        chk("model_pin_norm", model(24'h000F00, 10'd100, 5'd12), {24'hF00000, 10'd88, 2'b00});
        chk("model_pin_uflow", model(24'h000100, 10'd4, 5'd15), {24'h000800, 10'd0, 2'b01});

        one("basic",   24'h000F00, 10'd100, 5'd12, 24'hF00000, 10'd88, 1'b0, 1'b0);
        one("prenorm", 24'h800001, 10'd5,   5'd0,  24'h800001, 10'd5,  1'b0, 1'b0);
        one("uflow",   24'h000100, 10'd4,   5'd15, 24'h000800, 10'd0,  1'b0, 1'b1);
        one("zero",    24'h000000, 10'd50,  5'd23, 24'h000000, 10'd0,  1'b1, 1'b0);
        one("exp_one", 24'h800000, 10'd1,   5'd0,  24'h800000, 10'd1,  1'b0, 1'b0);
        one("exp_eq",  24'h000F00, 10'd12,  5'd12, 24'h780000, 10'd0,  1'b0, 1'b1);
        one("exp_neg", 24'h000100, 10'h3FD, 5'd15, 24'h000100, 10'd0,  1'b0, 1'b1);

        // Backpressure: downstream stalls for three cycles while four beats stream in.
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.out_ready = (k >= 3);
            if (sent < 4) drive(1'b1, (24'h800000 >> (sent + 1)) | 24'h1, 10'd50, CW'(sent + 1));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (k == 2) chk("bp_ready_drop", bus.in_ready, 0);
            if (k >= 3 && k <= 6) chk("bp_tput", bus.out_valid, 1);
            if (k == 7) chk("bp_drained", bus.out_valid, 0);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        chk("bp_sent", sent, 4);

        // Reset with both stages occupied.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 24'h00F000, 10'd40, 5'd8);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b1, 24'h0000FF, 10'd60, 5'd16);
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rf_full", bus.in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rf_valid", bus.out_valid, 0);
        chk("rf_out", {bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow}, 0);
        chk("rf_ready", bus.in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("rf_no_stale", bus.out_valid, 0);
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            lz = $urandom_range(0, MW);
            if (lz == MW) begin
                m = '0;
                l = CW'($urandom_range(0, (1 << CW) - 1));
            end else begin
                m = MW'((($urandom | 32'h800000) & 32'hFFFFFF) >> lz);
                l = CW'(lz);
            end
            if ($urandom_range(0, 1) == 1) e = EW'($urandom_range(0, 30));
            else e = EW'($urandom);
            drive($urandom_range(0, 3) != 0, m, e, l);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
